bfp_decomp_exp_axis: RTL and testbench

// - Parametrised BFP decompressor for O-RAN U-plane IQ; successor to the fixed 4-lane shift decompressor.
// - Takes unpacked, MSB-aligned compressed samples (LANES per beat) plus a per-PRB exponent.
// - Outputs saturated 16-bit network-order IQ on AXI-Stream with full tready backpressure.
// - Tracks PRB beats internally (no upstream state input) and flags PRB framing errors.
// - Sits between the bit unpacker and the U-plane output FIFO.

---
 rtl/bfp_pkg.sv | 21 ++
 rtl/bfp_lane_scale.sv | 39 +++
 rtl/bfp_decomp_exp_axis.sv | 110 +++++++++++
 tb/tb_bfp_decomp_exp_axis.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// rtl/bfp_pkg.sv - shared types and helpers for the BFP decompressor
package bfp_pkg;

  localparam int BFP_PRB_SAMPLES = 24;

  typedef logic [3:0] bfp_exp_t;
  typedef logic [3:0] bfp_width_t;

  function automatic logic [15:0] sat16(input logic signed [47:0] x);
    if (x > 48'sd32767) return 16'h7fff;
    else if (x < -48'sd32768) return 16'h8000;
    return x[15:0];
  endfunction

  // Keeps the top w bits of an MSB-aligned sample; width 0 means the full 16 bits.
  function automatic logic [15:0] width_mask(input bfp_width_t w);
    if (w == '0) return 16'hffff;
    return ~(16'hffff >> w);
  endfunction

endpackage

// File: rtl/bfp_lane_scale.sv
// rtl/bfp_lane_scale.sv - one lane of extract, shift and saturate (3 registered stages)
module bfp_lane_scale
  import bfp_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  logic [15:0] sample,
  input  bfp_width_t  width,
  input  bfp_exp_t    exp,
  input  logic [3:0]  fs,
  output logic [15:0] result,
  output logic        sat
);

  logic [15:0]        masked;
  logic [4:0]         shr;
  logic [4:0]         shl;
  logic signed [15:0] v_q;
  logic [4:0]         sh_q;
  logic signed [47:0] p_q;

  // Width 0 is raw 16-bit data: no extraction shift and no scaling.
  always_comb begin
    masked = sample & width_mask(width);
    shr    = (width == '0) ? 5'd0 : 5'd16 - {1'b0, width};
    shl    = (width == '0) ? 5'd0 : {1'b0, exp} + {1'b0, fs};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      v_q    <= $signed(masked) >>> shr;
      sh_q   <= shl;
      p_q    <= {{32{v_q[15]}}, v_q} <<< sh_q;
      result <= sat16(p_q);
      sat    <= (p_q > 48'sd32767) || (p_q < -48'sd32768);
    end
  end

endmodule

// File: rtl/bfp_decomp_exp_axis.sv
// rtl/bfp_decomp_exp_axis.sv - BFP exponent decompressor for U-plane IQ on AXI-Stream
module bfp_decomp_exp_axis
  import bfp_pkg::*;
#(
  parameter int LANES     = 4,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES*16-1:0]  s_axis_tdata,
  input  logic [3:0]           s_axis_texp,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [LANES*16-1:0]  m_axis_tdata,
  output logic [LANES*2-1:0]   m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  input  logic [3:0]           ud_iq_width,
  input  logic [3:0]           ctrl_fs_offset,
  output logic                 prb_err,
  output logic                 sat_pulse
);

  localparam int BEATS = BFP_PRB_SAMPLES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (LANES < 1 || (BFP_PRB_SAMPLES % LANES) != 0) begin : g_bad_lanes
    $fatal(1, "bfp_decomp_exp_axis: LANES must divide 24");
  end

  logic             en;
  logic             hs;
  logic             prb_start;
  logic [CW-1:0]    beat_cnt;
  bfp_exp_t         prb_exp;
  bfp_exp_t         cur_exp;
  bfp_width_t       prb_width;
  bfp_width_t       cur_width;
  logic [3:0]       prb_fs;
  logic [3:0]       cur_fs;
  logic [2:0]       vld;
  logic [2:0]       lst;
  logic [LANES-1:0] lane_sat;
  logic [15:0]      lane_res [LANES];

  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign hs            = s_axis_tvalid && en;
  assign prb_start     = (beat_cnt == '0);

  // The first beat of a PRB uses the live config; later beats use what it latched.
  assign cur_exp   = prb_start ? s_axis_texp    : prb_exp;
  assign cur_width = prb_start ? ud_iq_width    : prb_width;
  assign cur_fs    = prb_start ? ctrl_fs_offset : prb_fs;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      prb_exp   <= '0;
      prb_width <= '0;
      prb_fs    <= '0;
      vld       <= '0;
      lst       <= '0;
      prb_err   <= 1'b0;
    end else begin
      prb_err <= 1'b0;
      if (hs) begin
        if (prb_start) begin
          prb_exp   <= s_axis_texp;
          prb_width <= ud_iq_width;
          prb_fs    <= ctrl_fs_offset;
        end
        if (s_axis_tlast || beat_cnt == LAST_BEAT) beat_cnt <= '0;
        else beat_cnt <= beat_cnt + 1'b1;
        prb_err <= s_axis_tlast && (beat_cnt != LAST_BEAT);
      end
      if (en) begin
        vld <= {vld[1:0], s_axis_tvalid};
        lst <= {lst[1:0], s_axis_tvalid && s_axis_tlast};
      end
    end
  end

  assign m_axis_tvalid = vld[2];
  assign m_axis_tlast  = lst[2];
  assign m_axis_tkeep  = '1;
  assign sat_pulse     = vld[2] && m_axis_tready && (|lane_sat);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bfp_lane_scale u_lane (
      .clk    (clk),
      .en     (en),
      .sample (s_axis_tdata[16*k +: 16]),
      .width  (cur_width),
      .exp    (cur_exp),
      .fs     (cur_fs),
      .result (lane_res[k]),
      .sat    (lane_sat[k])
    );
    if (BYTE_SWAP) begin : g_swap
      assign m_axis_tdata[16*k +: 16] = {lane_res[k][7:0], lane_res[k][15:8]};
    end else begin : g_native
      assign m_axis_tdata[16*k +: 16] = lane_res[k];
    end
  end

endmodule

// File: tb/tb_bfp_decomp_exp_axis.sv
// tb/tb_bfp_decomp_exp_axis.sv - directed and randomised-backpressure bench for bfp_decomp_exp_axis
module tb_bfp_decomp_exp_axis;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_texp = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [3:0]  ud_iq_width = '0;
  logic [3:0]  ctrl_fs_offset = '0;
  logic        prb_err;
  logic        sat_pulse;

  always #5 clk = ~clk;

  bfp_decomp_exp_axis #(.LANES(LANES), .BYTE_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_texp(s_axis_texp), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .ud_iq_width(ud_iq_width), .ctrl_fs_offset(ctrl_fs_offset),
    .prb_err(prb_err), .sat_pulse(sat_pulse)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  texp, w, fs;
    logic        last;
    logic [63:0] exp_data;
    logic        exp_sat;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        sat;
  } beat_t;

  vec_t  tbl[$];
  beat_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 1;
  int    err_seen = 0;
  int    err_exp = 0;
  int    m_cnt = 0;
  logic [3:0] m_e = '0, m_w = '0, m_f = '0;

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  function automatic logic [63:0] swap_all(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = {d[16*k +: 8], d[16*k+8 +: 8]};
    return r;
  endfunction

  // {sat, value}: value of the top w bits times 2^(e+f), clamped to 16 bits.
  function automatic logic [16:0] ref_lane(input logic [15:0] x, input logic [3:0] w, e, f);
    longint v, r;
    if (w == 4'd0) return {1'b0, x};
    v = longint'($signed(x)) >>> (16 - int'(w));
    r = v * (longint'(1) << (int'(e) + int'(f)));
    if (r > 32767) return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic [63:0] d, input logic [3:0] e, w, f, input logic l,
                     input logic [63:0] x, input logic s);
    vec_t v;
    v.data = d; v.texp = e; v.w = w; v.fs = f; v.last = l; v.exp_data = x; v.exp_sat = s;
    tbl.push_back(v);
  endtask

  task automatic push(input logic [63:0] d, input logic l, input logic s);
    beat_t b;
    b.data = d; b.last = l; b.sat = s;
    sbq.push_back(b);
  endtask

  // Drives one beat until accepted; returns the model's expectation for it.
  task automatic send_beat(input logic [63:0] d, input logic [3:0] e, w, f, input logic l,
                           output logic [63:0] mexp, output logic msat);
    logic ok;
    logic [16:0] r;
    ok = 1'b0;
    mexp = '0;
    msat = 1'b0;
    @(negedge clk);
    s_axis_tdata = d; s_axis_texp = e; ud_iq_width = w; ctrl_fs_offset = f;
    s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #4;
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 64'(s_axis_tready), 64'd1);
    end else begin
      if (m_cnt == 0) begin
        m_e = e; m_w = w; m_f = f;
      end
      for (int k = 0; k < 4; k++) begin
        r = ref_lane(d[16*k +: 16], m_w, m_e, m_f);
        mexp[16*k +: 16] = r[15:0];
        msat = msat | r[16];
      end
      if (l && m_cnt != 5) err_exp++;
      m_cnt = (l || m_cnt == 5) ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int n = 0; n < 200 && sbq.size() != 0; n++) @(negedge clk);
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  // Output monitor: drives m_axis_tready and compares every output handshake in order.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      #4;
      if (!rst) begin
        if (prb_err) err_seen++;
        if (ready_mode == 2)
          check("s_tready_en", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
        if (m_axis_tvalid && m_axis_tready) begin
          if (sbq.size() == 0) begin
            check("unexpected_beat", 64'(sbq.size()), 64'd1);
          end else begin
            b = sbq.pop_front();
            check("m_tdata", m_axis_tdata, swap_all(b.data));
            check("m_tlast", 64'(m_axis_tlast), 64'(b.last));
            check("sat_pulse", 64'(sat_pulse), 64'(b.sat));
          end
        end else begin
          check("sat_idle", 64'(sat_pulse), 64'd0);
        end
      end
    end
  end

  initial begin
    logic [63:0] mx;
    logic        ms;
    logic [3:0]  re, rw, rf;

    // PRB A: W=9, exp=3; beats 1..5 drive different config that must be ignored.
    add(rep(16'hff80), 4'd3, 4'd9, 4'd0, 1'b0, rep(16'hfff8), 1'b0);
    add(rep(16'h0080), 4'd0, 4'd0, 4'd7, 1'b0, rep(16'h0008), 1'b0);
    add(rep(16'h7f80), 4'd0, 4'd0, 4'd7, 1'b0, rep(16'h07f8), 1'b0);
    add(rep(16'h8000), 4'd9, 4'd2, 4'd1, 1'b0, rep(16'hf800), 1'b0);
    add(rep(16'hff85), 4'd9, 4'd2, 4'd1, 1'b0, rep(16'hfff8), 1'b0);
    add(rep(16'h0100), 4'd0, 4'd0, 4'd0, 1'b1, rep(16'h0010), 1'b0);
    // PRB B: uncompressed, exp/fs ignored.
    add(64'h0000_ffff_8001_1234, 4'd7, 4'd0, 4'd5, 1'b0, 64'h0000_ffff_8001_1234, 1'b0);
    add(rep(16'h1234), 4'd7, 4'd0, 4'd5, 1'b0, rep(16'h1234), 1'b0);
    add(rep(16'h7fff), 4'd7, 4'd0, 4'd5, 1'b0, rep(16'h7fff), 1'b0);
    add(rep(16'h8000), 4'd7, 4'd0, 4'd5, 1'b0, rep(16'h8000), 1'b0);
    add(rep(16'h0001), 4'd7, 4'd0, 4'd5, 1'b0, rep(16'h0001), 1'b0);
    add(rep(16'h5a5a), 4'd7, 4'd0, 4'd5, 1'b1, rep(16'h5a5a), 1'b0);
    // PRB C: W=8, shift 18 saturates anything non-zero.
    add(rep(16'h7f00), 4'd15, 4'd8, 4'd3, 1'b0, rep(16'h7fff), 1'b1);
    add(rep(16'h8000), 4'd15, 4'd8, 4'd3, 1'b0, rep(16'h8000), 1'b1);
    add(rep(16'h0000), 4'd15, 4'd8, 4'd3, 1'b0, rep(16'h0000), 1'b0);
    add(64'h0000_0000_0000_0100, 4'd15, 4'd8, 4'd3, 1'b0, 64'h0000_0000_0000_7fff, 1'b1);
    add(rep(16'hff00), 4'd15, 4'd8, 4'd3, 1'b0, rep(16'h8000), 1'b1);
    add(rep(16'h00ff), 4'd15, 4'd8, 4'd3, 1'b1, rep(16'h0000), 1'b0);
    // PRB D: W=4, exp=2, fs=1 -> shift 3.
    add(64'h4000_f000_9000_7000, 4'd2, 4'd4, 4'd1, 1'b0, 64'h0020_fff8_ffc8_0038, 1'b0);
    add(rep(16'h8fff), 4'd2, 4'd4, 4'd1, 1'b0, rep(16'hffc0), 1'b0);
    add(rep(16'h1000), 4'd2, 4'd4, 4'd1, 1'b0, rep(16'h0008), 1'b0);
    add(rep(16'hf000), 4'd2, 4'd4, 4'd1, 1'b0, rep(16'hfff8), 1'b0);
    add(rep(16'h9000), 4'd2, 4'd4, 4'd1, 1'b0, rep(16'hffc8), 1'b0);
    add(rep(16'h4000), 4'd2, 4'd4, 4'd1, 1'b1, rep(16'h0020), 1'b0);

    ready_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_axis_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_prb_err", 64'(prb_err), 64'd0);
    check("rst_sat_pulse", 64'(sat_pulse), 64'd0);
    check("m_tkeep", 64'(m_axis_tkeep), 64'hff);

    foreach (tbl[i]) begin
      send_beat(tbl[i].data, tbl[i].texp, tbl[i].w, tbl[i].fs, tbl[i].last, mx, ms);
      push(tbl[i].exp_data, tbl[i].last, tbl[i].exp_sat);
      check("prb_err_legal", 64'(prb_err), 64'd0);
    end
    idle();
    drain();

    // Short PRB: tlast on the third beat, then a fresh exponent on the next beat.
    send_beat(rep(16'hff80), 4'd1, 4'd9, 4'd0, 1'b0, mx, ms);
    push(rep(16'hfffe), 1'b0, 1'b0);
    send_beat(rep(16'h0080), 4'd1, 4'd9, 4'd0, 1'b0, mx, ms);
    push(rep(16'h0002), 1'b0, 1'b0);
    send_beat(rep(16'h0100), 4'd1, 4'd9, 4'd0, 1'b1, mx, ms);
    push(rep(16'h0004), 1'b1, 1'b0);
    check("prb_err_short", 64'(prb_err), 64'd1);
    send_beat(rep(16'hff80), 4'd5, 4'd9, 4'd0, 1'b0, mx, ms);
    push(rep(16'hffe0), 1'b0, 1'b0);
    check("prb_err_cleared", 64'(prb_err), 64'd0);
    for (int b = 1; b < 6; b++) begin
      send_beat({$urandom, $urandom}, 4'd0, 4'd0, 4'd0, b == 5, mx, ms);
      push(mx, b == 5, ms);
    end
    idle();
    drain();

    // 100 PRBs with random backpressure, input gaps and mid-PRB config noise.
    ready_mode = 2;
    for (int p = 0; p < 100; p++) begin
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, 3) == 0) idle();
        re = 4'($urandom_range(0, 15));
        rw = 4'($urandom_range(0, 15));
        rf = 4'($urandom_range(0, 15));
        send_beat({$urandom, $urandom}, re, rw, rf, b == 5, mx, ms);
        push(mx, b == 5, ms);
      end
    end
    idle();
    drain();

    // Reset with beats stalled in the pipe.
    ready_mode = 0;
    send_beat(rep(16'hff80), 4'd3, 4'd9, 4'd0, 1'b0, mx, ms);
    send_beat(rep(16'hff80), 4'd3, 4'd9, 4'd0, 1'b0, mx, ms);
    idle();
    repeat (3) @(negedge clk);
    #4;
    check("stall_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_s_tready", 64'(s_axis_tready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    m_cnt = 0;
    ready_mode = 1;
    send_beat(rep(16'hff80), 4'd6, 4'd9, 4'd0, 1'b0, mx, ms);
    push(rep(16'hffc0), 1'b0, 1'b0);
    for (int b = 1; b < 6; b++) begin
      send_beat({$urandom, $urandom}, 4'd0, 4'd0, 4'd0, b == 5, mx, ms);
      push(mx, b == 5, ms);
    end
    idle();
    drain();

    check("prb_err_count", 64'(err_seen), 64'(err_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
